// File: rtl/p_hit_pkg.sv
// rtl/p_hit_pkg.sv - shared fixed-point types, FSM codes and saturation helper for p_hit_stream
package p_hit_pkg;

  localparam int FX_BITS = 32;
  localparam int FX_Q    = 16;

  typedef logic signed [FX_BITS-1:0] fx_t;
  typedef fx_t [2:0] vec3_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DOT   = 2'd1;
  localparam state_t ST_DIV   = 2'd2;
  localparam state_t ST_SCALE = 2'd3;

  // Clamp a sign-extended value into a signed word of 'bits' width (bits <= 64).
  function automatic logic signed [63:0] sat_to_fx(input logic signed [127:0] v, input int bits);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (bits - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (bits - 1));
    if (v > hi) return hi[63:0];
    else if (v < lo) return lo[63:0];
    else return v[63:0];
  endfunction

endpackage

// File: rtl/fixed_div_iter.sv
// rtl/fixed_div_iter.sv - signed fixed-point restoring divider, one quotient bit per cycle, saturating
module fixed_div_iter #(
  parameter int D_BITS = 32,
  parameter int Q_BITS = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [D_BITS-1:0] num,
  input  logic signed [D_BITS-1:0] den,
  output logic                     busy,
  output logic                     done,
  output logic signed [D_BITS-1:0] quot
);

  localparam int W        = D_BITS + Q_BITS;
  localparam int CNT_BITS = $clog2(W + 1);

  logic [D_BITS-1:0]   rem_q;
  logic [D_BITS-1:0]   dsr_q;
  logic [W-1:0]        dvd_q;
  logic [W-1:0]        quo_q;
  logic                neg_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic [D_BITS-1:0] num_mag;
  logic [D_BITS-1:0] den_mag;
  logic [D_BITS-1:0] cur_rem;
  logic [D_BITS-1:0] cur_dsr;
  logic [W-1:0]      cur_dvd;
  logic [W-1:0]      cur_quo;
  logic [D_BITS:0]   rem_sh;
  logic [D_BITS:0]   rem_sub;
  logic              ge;
  logic [D_BITS-1:0] next_rem;
  logic [W-1:0]      next_dvd;
  logic [W-1:0]      next_quo;
  logic [D_BITS-1:0] mag_sat;

  // The start cycle already performs the first iteration on the freshly loaded operands.
  always_comb begin
    num_mag  = num[D_BITS-1] ? D_BITS'(-num) : D_BITS'(num);
    den_mag  = den[D_BITS-1] ? D_BITS'(-den) : D_BITS'(den);
    cur_rem  = start ? '0 : rem_q;
    cur_dsr  = start ? den_mag : dsr_q;
    cur_dvd  = start ? {num_mag, {Q_BITS{1'b0}}} : dvd_q;
    cur_quo  = start ? '0 : quo_q;
    rem_sh   = {cur_rem, cur_dvd[W-1]};
    rem_sub  = rem_sh - {1'b0, cur_dsr};
    ge       = rem_sh >= {1'b0, cur_dsr};
    next_rem = ge ? rem_sub[D_BITS-1:0] : rem_sh[D_BITS-1:0];
    next_dvd = {cur_dvd[W-2:0], 1'b0};
    next_quo = {cur_quo[W-2:0], ge};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q <= '0;
      dsr_q <= '0;
      dvd_q <= '0;
      quo_q <= '0;
      neg_q <= 1'b0;
      cnt_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q <= next_rem;
        dsr_q <= den_mag;
        dvd_q <= next_dvd;
        quo_q <= next_quo;
        neg_q <= num[D_BITS-1] ^ den[D_BITS-1];
        cnt_q <= CNT_BITS'(W - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem_q <= next_rem;
        dvd_q <= next_dvd;
        quo_q <= next_quo;
        cnt_q <= cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    mag_sat = (|quo_q[W-1:D_BITS-1]) ? {1'b0, {(D_BITS-1){1'b1}}} : quo_q[D_BITS-1:0];
    quot    = neg_q ? -$signed(mag_sat) : $signed(mag_sat);
  end

endmodule

// File: rtl/p_hit_stream.sv
// rtl/p_hit_stream.sv - ray/plane hit point unit with iterative divide and sideband-carrying output FIFO
module p_hit_stream
  import p_hit_pkg::*;
#(
  parameter int D_BITS    = FX_BITS,
  parameter int Q_BITS    = FX_Q,
  parameter int SIDE_BITS = 320,
  parameter int OUT_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3*D_BITS-1:0]    tri_normal_in,
  input  logic [3*D_BITS-1:0]    v0_in,
  input  logic [3*D_BITS-1:0]    origin_in,
  input  logic [3*D_BITS-1:0]    dir_in,
  input  logic [SIDE_BITS-1:0]   side_in,
  input  logic                   in_wr_en,
  output logic                   in_full,
  output logic [3*D_BITS-1:0]    out_p_hit,
  output logic [D_BITS-1:0]      out_t,
  output logic                   out_hit,
  output logic [SIDE_BITS-1:0]   out_side,
  input  logic                   out_rd_en,
  output logic                   out_empty
);

  localparam int P_BITS   = 2 * D_BITS;
  localparam int S_BITS   = 2 * D_BITS + 2;
  localparam int ENT_BITS = 4 * D_BITS + 1 + SIDE_BITS;
  localparam int PTR_BITS = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  state_t state;

  logic signed [D_BITS-1:0] n_q   [3];
  logic signed [D_BITS-1:0] v0_q  [3];
  logic signed [D_BITS-1:0] org_q [3];
  logic signed [D_BITS-1:0] dir_q [3];
  logic [SIDE_BITS-1:0]     side_q;
  logic                     den_zero_q;

  logic signed [D_BITS-1:0] diff     [3];
  logic signed [P_BITS-1:0] num_prod [3];
  logic signed [P_BITS-1:0] den_prod [3];
  logic signed [P_BITS-1:0] scl_prod [3];
  logic signed [S_BITS-1:0] num_sum;
  logic signed [S_BITS-1:0] den_sum;
  logic signed [D_BITS-1:0] num_fx;
  logic signed [D_BITS-1:0] den_fx;
  logic signed [D_BITS-1:0] div_quot;
  logic signed [D_BITS-1:0] t_fx;
  logic [3*D_BITS-1:0]      p_vec;
  logic                     hit;
  logic                     div_start;
  logic                     div_busy;
  logic                     div_done;

  logic [ENT_BITS-1:0] mem [OUT_DEPTH];
  logic [ENT_BITS-1:0] head;
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic                accept;
  logic                push;
  logic                pop;

  assign in_full   = (state != ST_IDLE) || div_busy || (count == (PTR_BITS+1)'(OUT_DEPTH));
  assign accept    = in_wr_en && !in_full;
  assign div_start = (state == ST_DOT) && (den_fx != '0);
  assign push      = (state == ST_SCALE);
  assign pop       = out_rd_en && (count != '0);

  always_comb begin
    num_sum = '0;
    den_sum = '0;
    for (int i = 0; i < 3; i++) begin
      diff[i]     = v0_q[i] - org_q[i];
      num_prod[i] = P_BITS'(n_q[i]) * P_BITS'(diff[i]);
      den_prod[i] = P_BITS'(n_q[i]) * P_BITS'(dir_q[i]);
      num_sum     = num_sum + S_BITS'(num_prod[i]);
      den_sum     = den_sum + S_BITS'(den_prod[i]);
    end
    num_fx = D_BITS'(sat_to_fx(128'(num_sum >>> Q_BITS), D_BITS));
    den_fx = D_BITS'(sat_to_fx(128'(den_sum >>> Q_BITS), D_BITS));
  end

  // A parallel ray skips the divider; t is forced to zero so p collapses to the origin.
  always_comb begin
    p_vec = '0;
    t_fx  = den_zero_q ? '0 : div_quot;
    for (int i = 0; i < 3; i++) begin
      scl_prod[i] = P_BITS'(dir_q[i]) * P_BITS'(t_fx);
      p_vec[i*D_BITS +: D_BITS] = org_q[i] + D_BITS'(scl_prod[i] >>> Q_BITS);
    end
    hit = !den_zero_q && !t_fx[D_BITS-1];
  end

  fixed_div_iter #(
    .D_BITS (D_BITS),
    .Q_BITS (Q_BITS)
  ) u_div (
    .clock (clock),
    .reset (reset),
    .start (div_start),
    .num   (num_fx),
    .den   (den_fx),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      den_zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state <= ST_DOT;
        ST_DOT: begin
          den_zero_q <= (den_fx == '0);
          state      <= (den_fx == '0) ? ST_SCALE : ST_DIV;
        end
        ST_DIV:   if (div_done) state <= ST_SCALE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      for (int i = 0; i < 3; i++) begin
        n_q[i]   <= tri_normal_in[i*D_BITS +: D_BITS];
        v0_q[i]  <= v0_in[i*D_BITS +: D_BITS];
        org_q[i] <= origin_in[i*D_BITS +: D_BITS];
        dir_q[i] <= dir_in[i*D_BITS +: D_BITS];
      end
      side_q <= side_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_BITS'(OUT_DEPTH - 1)) ? '0 : wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_BITS'(OUT_DEPTH - 1)) ? '0 : rd_ptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_BITS+1)'(1);
        2'b01:   count <= count - (PTR_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {p_vec, t_fx, hit, side_q};
  end

  assign head      = mem[rd_ptr];
  assign out_empty = (count == '0);
  assign out_p_hit = out_empty ? '0 : head[ENT_BITS-1 -: 3*D_BITS];
  assign out_t     = out_empty ? '0 : head[SIDE_BITS+1 +: D_BITS];
  assign out_hit   = out_empty ? 1'b0 : head[SIDE_BITS];
  assign out_side  = out_empty ? '0 : head[SIDE_BITS-1:0];

endmodule

// File: tb/tb_p_hit_stream.sv
// tb/tb_p_hit_stream.sv - directed self-checking bench for p_hit_stream (Q16.16, OUT_DEPTH=2)
module tb_p_hit_stream;
  import p_hit_pkg::*;

  localparam int D     = FX_BITS;
  localparam int SB    = 320;
  localparam int DEPTH = 2;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic            clock = 1'b0;
  logic            reset;
  logic [3*D-1:0]  tri_normal_in;
  logic [3*D-1:0]  v0_in;
  logic [3*D-1:0]  origin_in;
  logic [3*D-1:0]  dir_in;
  logic [SB-1:0]   side_in;
  logic            in_wr_en;
  logic            in_full;
  logic [3*D-1:0]  out_p_hit;
  logic [D-1:0]    out_t;
  logic            out_hit;
  logic [SB-1:0]   out_side;
  logic            out_rd_en;
  logic            out_empty;

  int total  = 0;
  int passed = 0;

  p_hit_stream #(
    .D_BITS    (D),
    .Q_BITS    (FX_Q),
    .SIDE_BITS (SB),
    .OUT_DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tri_normal_in (tri_normal_in),
    .v0_in         (v0_in),
    .origin_in     (origin_in),
    .dir_in        (dir_in),
    .side_in       (side_in),
    .in_wr_en      (in_wr_en),
    .in_full       (in_full),
    .out_p_hit     (out_p_hit),
    .out_t         (out_t),
    .out_hit       (out_hit),
    .out_side      (out_side),
    .out_rd_en     (out_rd_en),
    .out_empty     (out_empty)
  );

  always #5 clock = ~clock;

  function automatic logic [3*D-1:0] v3(input logic [D-1:0] x, input logic [D-1:0] y, input logic [D-1:0] z);
    return {z, y, x};
  endfunction

  task automatic check(input string tag, input logic [SB-1:0] obs, input logic [SB-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3*D-1:0] dir, input logic [3*D-1:0] org, input logic [SB-1:0] side);
    dir_in    = dir;
    origin_in = org;
    side_in   = side;
  endtask

  task automatic push(input logic [3*D-1:0] dir, input logic [3*D-1:0] org, input logic [SB-1:0] side);
    load(dir, org, side);
    in_wr_en = 1'b1;
    tick();
    in_wr_en = 1'b0;
  endtask

  task automatic pop();
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  // Cycle index counts the accept cycle as N, so an entry visible right after the accept edge is N+1.
  task automatic wait_out(input string tag, input int exp_cycle);
    int k;
    k = 0;
    while (out_empty && k < 200) begin
      tick();
      k++;
    end
    check(tag, SB'(k + 1), SB'(exp_cycle));
  endtask

  task automatic check_res(input string tag, input logic [3*D-1:0] p, input logic [D-1:0] t,
                           input logic hit, input logic [SB-1:0] side);
    check({tag, ".p"}, SB'(out_p_hit), SB'(p));
    check({tag, ".t"}, SB'(out_t), SB'(t));
    check({tag, ".hit"}, SB'(out_hit), SB'(hit));
    check({tag, ".side"}, out_side, side);
  endtask

  initial begin
    reset         = 1'b1;
    in_wr_en      = 1'b0;
    out_rd_en     = 1'b0;
    tri_normal_in = '0;
    v0_in         = '0;
    origin_in     = '0;
    dir_in        = '0;
    side_in       = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst.empty", SB'(out_empty), SB'(1));
    check("rst.full", SB'(in_full), SB'(0));
    check("rst.p", SB'(out_p_hit), '0);
    check("rst.t", SB'(out_t), '0);
    check("rst.hit", SB'(out_hit), '0);
    check("rst.side", out_side, '0);

    tri_normal_in = v3(32'h0, 32'h0, ONE);
    v0_in         = v3(32'h0, 32'h0, 32'h0005_0000);

    // Straight hit along +z
    push(v3(32'h0, 32'h0, ONE), '0, SB'('hA5));
    check("t1.busy", SB'(in_full), SB'(1));
    wait_out("t1.lat", 51);
    check_res("t1", v3(32'h0, 32'h0, 32'h0005_0000), 32'h0005_0000, 1'b1, SB'('hA5));
    pop();
    check("t1.popped", SB'(out_empty), SB'(1));

    // Offset origin with a fractional direction component
    push(v3(32'h0000_8000, 32'h0, 32'h0002_0000), v3(ONE, 32'h0002_0000, ONE), SB'('h1B));
    wait_out("t1b.lat", 51);
    check_res("t1b", v3(32'h0002_0000, 32'h0002_0000, 32'h0005_0000), 32'h0002_0000, 1'b1, SB'('h1B));
    pop();

    // Parallel ray: bypasses the divider
    push(v3(ONE, 32'h0, 32'h0), v3(32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000), SB'('h5A));
    wait_out("t2.lat", 3);
    check_res("t2", v3(32'h0001_8000, 32'hFFFF_0000, 32'h0000_4000), 32'h0, 1'b0, SB'('h5A));
    pop();

    // Plane behind the ray: t negative, still computed
    push(v3(32'h0, 32'h0, 32'hFFFF_0000), '0, SB'('h3C));
    wait_out("t3.lat", 51);
    check_res("t3", v3(32'h0, 32'h0, 32'h0005_0000), 32'hFFFB_0000, 1'b0, SB'('h3C));
    pop();

    // Tiny denominator: quotient saturates
    push(v3(32'h0, 32'h0, 32'h0000_0001), '0, SB'('h77));
    wait_out("t4.lat", 51);
    check_res("t4", v3(32'h0, 32'h0, 32'h0000_7FFF), 32'h7FFF_FFFF, 1'b1, SB'('h77));
    pop();
    check("t4.popped", SB'(out_empty), SB'(1));

    // Full output FIFO back-pressures the input
    push(v3(ONE, 32'h0, 32'h0), v3(32'h0003_0000, 32'h0, 32'h0), SB'('h101));
    wait_out("t5.a.lat", 3);
    push(v3(32'h0, 32'h0, ONE), '0, SB'('h102));
    repeat (60) tick();
    check("t5.full", SB'(in_full), SB'(1));
    push(v3(32'h0000_8000, 32'h0, 32'h0002_0000), v3(ONE, 32'h0002_0000, ONE), SB'('h103));
    check("t5.refused", SB'(in_full), SB'(1));
    check_res("t5.a", v3(32'h0003_0000, 32'h0, 32'h0), 32'h0, 1'b0, SB'('h101));
    pop();
    check("t5.unfull", SB'(in_full), SB'(0));
    push(v3(32'h0000_8000, 32'h0, 32'h0002_0000), v3(ONE, 32'h0002_0000, ONE), SB'('h103));
    repeat (60) tick();
    check_res("t5.b", v3(32'h0, 32'h0, 32'h0005_0000), 32'h0005_0000, 1'b1, SB'('h102));
    pop();
    check_res("t5.c", v3(32'h0002_0000, 32'h0002_0000, 32'h0005_0000), 32'h0002_0000, 1'b1, SB'('h103));
    pop();
    check("t5.drained", SB'(out_empty), SB'(1));

    // Pop and push on the same edge
    push(v3(ONE, 32'h0, 32'h0), '0, SB'('h201));
    wait_out("t7.a.lat", 3);
    push(v3(ONE, 32'h0, 32'h0), v3(32'h0, 32'h0007_0000, 32'h0), SB'('h202));
    tick();
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
    check("t7.nonempty", SB'(out_empty), SB'(0));
    check_res("t7.b", v3(32'h0, 32'h0007_0000, 32'h0), 32'h0, 1'b0, SB'('h202));
    pop();
    check("t7.drained", SB'(out_empty), SB'(1));

    // Reset while the divider is running
    push(v3(32'h0, 32'h0, ONE), '0, SB'('hBB));
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6.empty", SB'(out_empty), SB'(1));
    check("t6.full", SB'(in_full), SB'(0));
    repeat (60) tick();
    check("t6.dropped", SB'(out_empty), SB'(1));
    push(v3(32'h0, 32'h0, 32'h0000_0001), '0, SB'('hCC));
    wait_out("t6.lat", 51);
    check_res("t6", v3(32'h0, 32'h0, 32'h0000_7FFF), 32'h7FFF_FFFF, 1'b1, SB'('hCC));
    pop();
    check("t6.drained", SB'(out_empty), SB'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
